// File: rtl/rgb_led_pwm.sv
// rgb_led_pwm: drives the board RGB LED with 16-level PWM in one of four modes
// (off, steady, blink, breathe). Switch inputs are synchronised and only take
// effect on PWM frame boundaries so the LED never glitches mid-frame.
module rgb_led_pwm #(
  parameter int PWM_DIV        = 64,   // clk cycles per PWM step, >= 2
  parameter int BLINK_FRAMES   = 1024, // frames per blink half-period, >= 1
  parameter int BREATHE_FRAMES = 64    // frames per breathe level step, >= 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] color_in,
  input  logic [3:0] duty,
  input  logic [1:0] mode,
  output logic [2:0] led_out,
  output logic       frame_tick
);

  localparam int             PRE_W       = $clog2(PWM_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PWM_DIV - 1);
  localparam logic [15:0]    BLINK_LAST  = 16'(BLINK_FRAMES - 1);
  localparam logic [15:0]    BR_LAST     = 16'(BREATHE_FRAMES - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_STEADY,
    S_BLINK_ON,
    S_BLINK_OFF,
    S_BR_UP,
    S_BR_DOWN
  } state_e;

  logic [2:0]       color_s1_q, color_s2_q, color_sh_q, color_sh_d;
  logic [3:0]       duty_s1_q, duty_s2_q, duty_sh_q, duty_sh_d;
  logic [1:0]       mode_s1_q, mode_s2_q, mode_sh_q, mode_sh_d;
  logic [PRE_W-1:0] pre_q;
  logic [3:0]       pcnt_q;
  logic [15:0]      fcnt_q, fcnt_inc;
  logic [3:0]       lvl_q;
  state_e           state_q;
  logic [3:0]       eff;
  logic             step, frame_bnd, pwm_on;
  logic [2:0]       led_q;
  logic             frame_tick_q;

  assign step      = (pre_q == PRE_LAST);
  assign frame_bnd = step && (pcnt_q == 4'hF);
  assign fcnt_inc  = (fcnt_q == 16'hFFFF) ? fcnt_q : fcnt_q + 16'd1;

  // Two-flop synchronisers for the switch-derived inputs.
  always_ff @(posedge clk) begin
    // NOTE: synchroniser flops are reset as well, so the first frame boundary
    // after reset can never load an X into the shadow registers.
    if (rst) begin
      color_s1_q <= '0;
      color_s2_q <= '0;
      duty_s1_q  <= '0;
      duty_s2_q  <= '0;
      mode_s1_q  <= '0;
      mode_s2_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep s1 and s2 as two distinct stages;
      // blocking ones here would collapse the synchroniser to a single flop.
      color_s1_q <= color_in;
      color_s2_q <= color_s1_q;
      duty_s1_q  <= duty;
      duty_s2_q  <= duty_s1_q;
      mode_s1_q  <= mode;
      mode_s2_q  <= mode_s1_q;
    end
  end

  // Prescaler and PWM slot counter; frame_tick flags the boundary edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q        <= '0;
      pcnt_q       <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      pre_q        <= step ? '0 : pre_q + 1'b1;
      if (step) pcnt_q <= pcnt_q + 4'd1;
      frame_tick_q <= frame_bnd;
    end
  end

  // Shadow values seen at the coming edge: synchronised inputs on a boundary.
  always_comb begin
    // NOTE: defaults first, so every path assigns and no latch is inferred.
    color_sh_d = color_sh_q;
    duty_sh_d  = duty_sh_q;
    mode_sh_d  = mode_sh_q;
    if (frame_bnd) begin
      color_sh_d = color_s2_q;
      duty_sh_d  = duty_s2_q;
      mode_sh_d  = mode_s2_q;
    end
  end

  // Shadow registers and mode FSM; the FSM acts on the freshly loaded shadows.
  always_ff @(posedge clk) begin
    if (rst) begin
      color_sh_q <= '0;
      duty_sh_q  <= '0;
      mode_sh_q  <= '0;
      state_q    <= S_OFF;
      lvl_q      <= '0;
      fcnt_q     <= '0;
    end else begin
      color_sh_q <= color_sh_d;
      duty_sh_q  <= duty_sh_d;
      mode_sh_q  <= mode_sh_d;
      if (frame_bnd) begin
        if (mode_sh_d != mode_sh_q) begin
          // A mode change overrides any blink/breathe step due this boundary.
          fcnt_q <= '0;
          unique case (mode_sh_d)
            2'b00:   state_q <= S_OFF;
            2'b01:   state_q <= S_STEADY;
            2'b10:   state_q <= S_BLINK_ON;
            default: begin
              state_q <= S_BR_UP;
              lvl_q   <= '0;
            end
          endcase
        end else begin
          unique case (mode_sh_d)
            2'b00: begin
              state_q <= S_OFF;
              fcnt_q  <= fcnt_inc;
            end
            2'b01: begin
              state_q <= S_STEADY;
              fcnt_q  <= fcnt_inc;
            end
            2'b10: begin
              if (fcnt_q == BLINK_LAST) begin
                fcnt_q  <= '0;
                state_q <= (state_q == S_BLINK_ON) ? S_BLINK_OFF : S_BLINK_ON;
              end else begin
                fcnt_q <= fcnt_inc;
              end
            end
            default: begin
              if (duty_sh_d < lvl_q) begin
                // Brightness cut below the current level: clamp and descend.
                lvl_q   <= duty_sh_d;
                state_q <= S_BR_DOWN;
                fcnt_q  <= (fcnt_q == BR_LAST) ? '0 : fcnt_inc;
              end else if (fcnt_q == BR_LAST) begin
                fcnt_q <= '0;
                if (state_q == S_BR_UP) begin
                  if (lvl_q < duty_sh_d) lvl_q <= lvl_q + 4'd1;
                  else                   state_q <= S_BR_DOWN;
                end else begin
                  if (lvl_q != 4'd0) lvl_q <= lvl_q - 4'd1;
                  else               state_q <= S_BR_UP;
                end
              end else begin
                fcnt_q <= fcnt_inc;
              end
            end
          endcase
        end
      end
    end
  end

  // Effective brightness for the current frame and the PWM compare.
  always_comb begin
    eff = 4'd0;
    unique case (state_q)
      S_STEADY, S_BLINK_ON: eff = duty_sh_q;
      S_BR_UP, S_BR_DOWN:   eff = lvl_q;
      default:              eff = 4'd0;
    endcase
  end

  assign pwm_on = (eff == 4'hF) || (pcnt_q < eff);

  // Registered LED drive: no combinational path from any input.
  always_ff @(posedge clk) begin
    if (rst) led_q <= '0;
    else     led_q <= color_sh_q & {3{pwm_on}};
  end

  assign led_out    = led_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_rgb_led_pwm.sv
// tb_rgb_led_pwm: frame-level scoreboard bench for rgb_led_pwm. Stimulus sets
// inputs once per frame and pushes the expected frame (colour, brightness)
// from a behavioural model; a monitor collects each 32-cycle frame of led_out
// between frame_tick pulses and compares it against the popped expectation.
module tb_rgb_led_pwm;

  localparam int PWM_DIV        = 2;
  localparam int BLINK_FRAMES   = 2;
  localparam int BREATHE_FRAMES = 1;
  localparam int FRAME_CYC      = 16 * PWM_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] color_in;
  logic [3:0] duty;
  logic [1:0] mode;
  logic [2:0] led_out;
  logic       frame_tick;

  rgb_led_pwm #(
    .PWM_DIV       (PWM_DIV),
    .BLINK_FRAMES  (BLINK_FRAMES),
    .BREATHE_FRAMES(BREATHE_FRAMES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .color_in  (color_in),
    .duty      (duty),
    .mode      (mode),
    .led_out   (led_out),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] color;
    int         eff;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_push   = 0;
  int   n_frames = 0;
  bit   mon_en   = 1'b1;

  // Behavioural model state: what the LED should be doing frame by frame.
  int m_mode, m_fc, m_lvl;
  bit m_blink_lit, m_rising;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_fc = 0; m_lvl = 0; m_blink_lit = 1'b1; m_rising = 1'b1;
  endtask

  // Advance the model by one frame boundary that sees (c, d, m); push result.
  task automatic push_expect(input logic [2:0] c, input int d, input int m);
    exp_t e;
    if (m != m_mode) begin
      m_fc = 0;
      if (m == 2) m_blink_lit = 1'b1;
      if (m == 3) begin m_lvl = 0; m_rising = 1'b1; end
    end else if (m == 2) begin
      if (m_fc == BLINK_FRAMES - 1) begin m_blink_lit = !m_blink_lit; m_fc = 0; end
      else m_fc++;
    end else if (m == 3) begin
      if (d < m_lvl) begin
        m_lvl = d; m_rising = 1'b0;
        m_fc = (m_fc == BREATHE_FRAMES - 1) ? 0 : m_fc + 1;
      end else if (m_fc == BREATHE_FRAMES - 1) begin
        m_fc = 0;
        if (m_rising) begin
          if (m_lvl < d) m_lvl++; else m_rising = 1'b0;
        end else begin
          if (m_lvl > 0) m_lvl--; else m_rising = 1'b1;
        end
      end else m_fc++;
    end else if (m_fc < 65535) m_fc++;
    m_mode = m;
    e.color = c;
    case (m)
      1:       e.eff = d;
      2:       e.eff = m_blink_lit ? d : 0;
      3:       e.eff = m_lvl;
      default: e.eff = 0;
    endcase
    exp_q.push_back(e);
    n_push++;
  endtask

  // Monitor: collect one frame of led_out between ticks and score it.
  initial begin : monitor
    logic [2:0] buf_q[$];
    bit collecting = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        collecting = 1'b0;
        buf_q.delete();
      end else begin
        if (collecting) buf_q.push_back(led_out);
        if (frame_tick) begin
          if (collecting) begin
            exp_t e;
            int bad, first;
            logic [2:0] want, got;
            checks++;
            n_frames++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL frame %0d: no expectation queued", n_frames);
            end else begin
              e = exp_q.pop_front();
              bad = 0; first = -1; want = '0; got = '0;
              for (int j = 0; j < FRAME_CYC; j++) begin
                logic [2:0] w;
                logic [2:0] a;
                w = (e.eff == 15 || (j / PWM_DIV) < e.eff) ? e.color : 3'b000;
                a = (j < buf_q.size()) ? buf_q[j] : 3'bxxx;
                if (a !== w) begin
                  bad++;
                  if (first < 0) begin first = j; want = w; got = a; end
                end
              end
              if (bad != 0 || buf_q.size() != FRAME_CYC) begin
                failures++;
                $display("FAIL frame %0d (color=%b eff=%0d): len %0d, %0d bad samples, first at %0d got %b expected %b",
                         n_frames, e.color, e.eff, buf_q.size(), bad, first, got, want);
              end
            end
          end
          collecting = 1'b1;
          buf_q.delete();
        end
      end
    end
  end

  // Bounded wait for the next frame_tick, sampled on the falling edge.
  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < FRAME_CYC + 8 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wait_tick: no frame_tick within %0d cycles", FRAME_CYC + 8);
    end
  endtask

  // One frame of stimulus, optionally with a change that reverts mid-frame.
  task automatic run_frame(input logic [2:0] c, input logic [3:0] d, input logic [1:0] m,
                           input bit glitch);
    color_in = c; duty = d; mode = m;
    push_expect(c, int'(d), int'(m));
    if (glitch) begin
      repeat ($urandom_range(2, 10)) @(negedge clk);
      color_in = 3'($urandom);
      duty     = 4'($urandom);
      mode     = 2'($urandom);
      repeat ($urandom_range(1, 8)) @(negedge clk);
      color_in = c; duty = d; mode = m;
    end
    wait_tick();
  endtask

  // Count cycles from reset release to the first frame_tick; LED stays dark.
  task automatic check_first_tick(input string name);
    int cyc = 0, lit = 0;
    bit seen = 1'b0;
    while (!seen && cyc < FRAME_CYC + 8) begin
      @(negedge clk);
      cyc++;
      if (led_out != 3'b000) lit++;
      if (frame_tick) seen = 1'b1;
    end
    check({name, "_cycles"}, cyc, FRAME_CYC);
    check({name, "_dark"}, lit, 0);
  endtask

  initial begin : stimulus
    logic [1:0] rm;
    rst = 1'b1; color_in = 3'b111; mode = 2'b01; duty = 4'd15;
    model_reset();
    // The first boundary after release loads these held inputs.
    push_expect(3'b111, 15, 1);
    repeat (5) begin
      @(negedge clk);
      check("reset_led", led_out, 3'b000);
      check("reset_tick", frame_tick, 1'b0);
    end
    rst = 1'b0;
    check_first_tick("first_tick");

    // Steady: partial, zero and full brightness.
    repeat (3) run_frame(3'b101, 4'd4, 2'b01, 1'b0);
    repeat (2) run_frame(3'b101, 4'd0, 2'b01, 1'b0);
    repeat (2) run_frame(3'b101, 4'd15, 2'b01, 1'b0);
    // Blink: two frames lit, two dark.
    repeat (8) run_frame(3'b010, 4'd15, 2'b10, 1'b0);
    // Breathe up and down, then cut duty below the level at lvl=3 rising.
    repeat (12) run_frame(3'b001, 4'd3, 2'b11, 1'b0);
    repeat (4) run_frame(3'b001, 4'd1, 2'b11, 1'b0);
    // Breathe with duty 0 stays dark.
    repeat (3) run_frame(3'b111, 4'd0, 2'b11, 1'b0);
    // Inputs that glitch and revert inside a frame must not be seen.
    repeat (4) run_frame(3'b101, 4'd4, 2'b01, 1'b1);
    repeat (3) run_frame(3'b110, 4'd9, 2'b10, 1'b1);

    // Random frames: mostly hold the mode so blink/breathe get to progress.
    rm = 2'b01;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) < 3) rm = 2'($urandom);
      run_frame(3'($urandom), 4'($urandom), rm, ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a lit blink frame.
    run_frame(3'b010, 4'd15, 2'b01, 1'b0);
    run_frame(3'b010, 4'd15, 2'b10, 1'b0);
    repeat (10) @(negedge clk);
    check("frames_scored", n_frames, n_push - 1);
    check("blink_lit_before_rst", led_out, 3'b010);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_led", led_out, 3'b000);
    check("rst_tick", frame_tick, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check_first_tick("rerun_tick");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
